// File: rtl/bsg_manycore_fifo_req_issue_queue.sv
// Credit-aware outgoing request queue feeding the endpoint_req port of the manycore endpoint.
// It buffers fifo-format request packets and caps the number of requests in flight at
// max_out_p. Issued requests are counted against returned responses. A fence drains the
// queue, waits for every response to return, and then pulses fence_done_o for one cycle.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   enq_v_i/enq_data_i        producer packet in; enq_ready_o is high when it is accepted
//   endpoint_req_o/_v_o       head packet out; endpoint_req_ready_i accepts it (an issue)
//   mc_rsp_v_i/mc_rsp_ready_i monitored response handshake; each handshake retires one request
//   fence_i                   fence request, sampled only in RUN
//   fence_done_o              one-cycle pulse when a fence completes
//   outstanding_o             number of requests in flight
//   idle_o                    queue empty and nothing in flight
//   err_o                     sticky flag: a response arrived with nothing outstanding
module bsg_manycore_fifo_req_issue_queue #(
    parameter int unsigned fifo_width_p = 128,
    parameter int unsigned els_p        = 4,
    parameter int unsigned max_out_p    = 32,
    parameter int unsigned cnt_width_lp = $clog2(max_out_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    enq_v_i,
    input  logic [fifo_width_p-1:0] enq_data_i,
    output logic                    enq_ready_o,
    output logic [fifo_width_p-1:0] endpoint_req_o,
    output logic                    endpoint_req_v_o,
    input  logic                    endpoint_req_ready_i,
    input  logic                    mc_rsp_v_i,
    input  logic                    mc_rsp_ready_i,
    input  logic                    fence_i,
    output logic                    fence_done_o,
    output logic [cnt_width_lp-1:0] outstanding_o,
    output logic                    idle_o,
    output logic                    err_o
);

    localparam int unsigned ptr_width_lp   = $clog2(els_p);
    localparam int unsigned count_width_lp = $clog2(els_p + 1);

    localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] els_lp      = count_width_lp'(els_p);
    localparam logic [cnt_width_lp-1:0]   max_out_lp  = cnt_width_lp'(max_out_p);

    typedef enum logic [1:0] {StRun, StDrain, StWait} state_e;

    state_e                    state_q, state_d;
    logic [fifo_width_p-1:0]   mem_q [els_p];
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic [cnt_width_lp-1:0]   outstanding_q, outstanding_d;
    logic                      err_q, err_d;
    logic                      fence_done_q, fence_done_d;
    logic                      enq, issue, rsp;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= StRun;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            fence_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            fence_done_q  <= fence_done_d;
        end
    end

    // Packet storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= enq_data_i;
        end
    end

    // Handshakes
    always_comb begin
        enq_ready_o      = (count_q < els_lp) && (state_q == StRun);
        endpoint_req_v_o = (count_q != '0) && (outstanding_q < max_out_lp) && (state_q != StWait);
        endpoint_req_o   = mem_q[rd_ptr_q];
        enq              = enq_v_i && enq_ready_o;
        issue            = endpoint_req_v_o && endpoint_req_ready_i;
        rsp              = mc_rsp_v_i && mc_rsp_ready_i;
    end

    // Datapath next state: pointers, occupancy, credit counter
    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        if (enq) begin
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
        end
        if (enq && !issue) begin
            count_d = count_q + 1'b1;
        end else if (!enq && issue) begin
            count_d = count_q - 1'b1;
        end

        if (issue && !rsp) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue && rsp) begin
            // A response with no request in flight is a protocol error; keep the counter at 0.
            if (outstanding_q == '0) begin
                err_d = 1'b1;
            end else begin
                outstanding_d = outstanding_q - 1'b1;
            end
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (fence_i) state_d = StDrain;
            // Uses registered count, so the final issue moves us on the following cycle.
            StDrain: if (count_q == '0) state_d = StWait;
            StWait:  if (outstanding_q == '0) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM outputs: the done pulse is registered so it appears in the first RUN cycle
    always_comb begin
        fence_done_d = (state_q == StWait) && (outstanding_q == '0);
        fence_done_o = fence_done_q;
        outstanding_o = outstanding_q;
        idle_o        = (count_q == '0) && (outstanding_q == '0);
        err_o         = err_q;
    end

endmodule
